// File: rtl/fptd_iteration_controller_if.sv
// fptd_iteration_controller_if: frame-loader / decoder-array signals of the iteration controller
interface fptd_iteration_controller_if #(
    parameter int FL    = 104,
    parameter int CNT_W = 6
);
    logic             Start;
    logic [CNT_W-1:0] Num_Half_Iter;
    logic [FL-1:0]    Razor_Error;
    logic             Ready;
    logic             nClear;
    logic             Enable_Term;
    logic             Enable_Odd;
    logic             Enable_Even;
    logic             Enable_Error_Counter;
    logic             Done;
    logic [7:0]       Replay_Count;
    logic             Replay_Fail;
    modport master (
        output Start, Num_Half_Iter, Razor_Error,
        input  Ready, nClear, Enable_Term, Enable_Odd, Enable_Even, Enable_Error_Counter,
               Done, Replay_Count, Replay_Fail
    );
    modport slave (
        input  Start, Num_Half_Iter, Razor_Error,
        output Ready, nClear, Enable_Term, Enable_Odd, Enable_Even, Enable_Error_Counter,
               Done, Replay_Count, Replay_Fail
    );
endinterface

// File: rtl/fptd_iteration_controller.sv
// fptd_iteration_controller: per-frame clear/termination/half-iteration sequencer with Razor-triggered replay
module fptd_iteration_controller #(
    parameter int FL         = 104,
    parameter int CNT_W      = 6,
    parameter int TERM_CYC   = 3,
    parameter int MAX_REPLAY = 3
) (
    input logic                       Clock,
    input logic                       nReset,
    fptd_iteration_controller_if.slave bus
);
    localparam int TW = $clog2(TERM_CYC + 1);
    localparam int RW = $clog2(MAX_REPLAY + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, TERM, ITER_EN, ITER_CHK, COUNT, DONE} state_t;
    state_t           state_q, state_d;
    logic [TW-1:0]    term_q, term_d;
    logic [CNT_W-1:0] h_q, h_d, nh_q, nh_d, h_inc;
    logic [RW-1:0]    r_q, r_d;
    logic [7:0]       rc_q, rc_d;
    logic             rf_q, rf_d, err;
    logic [FL-1:0]    razor;
    assign razor = bus.Razor_Error;
    assign err   = |razor;
    assign h_inc = h_q + 1'b1;
    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        h_d     = h_q;
        nh_d    = nh_q;
        r_d     = r_q;
        rc_d    = rc_q;
        rf_d    = rf_q;
        case (state_q)
            IDLE: if (bus.Start) begin
                state_d = CLEAR;
                nh_d    = (bus.Num_Half_Iter == '0) ? CNT_W'(1) : bus.Num_Half_Iter;
                h_d     = '0;
                r_d     = '0;
                rc_d    = '0;
                rf_d    = 1'b0;
            end
            CLEAR: begin
                state_d = TERM;
                term_d  = '0;
            end
            TERM: begin
                term_d = term_q + 1'b1;
                if (term_q == TW'(TERM_CYC - 1)) state_d = ITER_EN;
            end
            ITER_EN: state_d = ITER_CHK;
            // a flagged half-iteration is retried until its replay budget runs out
            ITER_CHK: if (err && r_q != RW'(MAX_REPLAY)) begin
                state_d = ITER_EN;
                r_d     = r_q + 1'b1;
                rc_d    = (rc_q == 8'hff) ? rc_q : rc_q + 1'b1;
            end else begin
                rf_d    = rf_q | err;
                r_d     = '0;
                h_d     = h_inc;
                state_d = (h_inc == nh_q) ? COUNT : ITER_EN;
            end
            COUNT:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            term_q  <= '0;
            h_q     <= '0;
            nh_q    <= '0;
            r_q     <= '0;
            rc_q    <= '0;
            rf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            h_q     <= h_d;
            nh_q    <= nh_d;
            r_q     <= r_d;
            rc_q    <= rc_d;
            rf_q    <= rf_d;
        end
    end
    assign bus.Ready                = state_q == IDLE;
    assign bus.nClear               = state_q != CLEAR;
    assign bus.Enable_Term          = state_q == TERM;
    assign bus.Enable_Odd           = state_q == ITER_EN && !h_q[0];
    assign bus.Enable_Even          = state_q == ITER_EN && h_q[0];
    assign bus.Enable_Error_Counter = state_q == COUNT;
    assign bus.Done                 = state_q == DONE;
    assign bus.Replay_Count         = rc_q;
    assign bus.Replay_Fail          = rf_q;
endmodule

// File: tb/tb_fptd_iteration_controller.sv
// tb_fptd_iteration_controller: random frames checked cycle-by-cycle against a timeline model
module tb_fptd_iteration_controller;
    localparam int FL = 104, CNT_W = 6, TC = 3, MR = 3, MAXC = 1024;
    logic Clock, nReset;
    int total, bad, cyc;
    bit cmp_on;
    bit errv [MAXC];
    bit e_rdy [MAXC], e_ncl [MAXC], e_trm [MAXC], e_odd [MAXC], e_evn [MAXC], e_ec [MAXC], e_dn [MAXC], e_rf [MAXC];
    int e_rc [MAXC];
    int len;

    fptd_iteration_controller_if #(.FL(FL), .CNT_W(CNT_W)) bus ();
    fptd_iteration_controller #(.FL(FL), .CNT_W(CNT_W), .TERM_CYC(TC), .MAX_REPLAY(MR)) dut (
        .Clock(Clock), .nReset(nReset), .bus(bus)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;
    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, expv);
        end
    endtask

    function automatic logic [FL-1:0] rv();
        logic [FL-1:0] v;
        v = '0;
        v[$urandom_range(FL - 1, 0)] = 1'b1;
        if ($urandom % 2 == 1) v[$urandom_range(FL - 1, 0)] = 1'b1;
        return v;
    endfunction

    // Frame timeline from the cycle-count rules: one enable + one check per attempt.
    task automatic build_model(input int nh_in, output int l);
        int nh, t, r, rc;
        bit rf;
        nh = (nh_in == 0) ? 1 : nh_in;
        for (int k = 0; k < MAXC; k++) begin
            e_rdy[k] = 0; e_ncl[k] = 1; e_trm[k] = 0; e_odd[k] = 0; e_evn[k] = 0;
            e_ec[k] = 0; e_dn[k] = 0; e_rc[k] = 0; e_rf[k] = 0;
        end
        e_ncl[1] = 0;
        for (int k = 2; k <= 1 + TC; k++) e_trm[k] = 1;
        t = 2 + TC; rc = 0; rf = 0;
        for (int h = 0; h < nh; h++) begin
            r = 0;
            forever begin
                if (h % 2 == 0) e_odd[t] = 1; else e_evn[t] = 1;
                if (errv[t + 1] && r < MR) begin
                    r++;
                    rc = (rc == 255) ? 255 : rc + 1;
                    for (int j = t + 2; j < MAXC; j++) e_rc[j] = rc;
                    t += 2;
                end else begin
                    if (errv[t + 1]) begin
                        rf = 1;
                        for (int j = t + 2; j < MAXC; j++) e_rf[j] = 1;
                    end
                    t += 2;
                    break;
                end
            end
        end
        e_ec[t] = 1;
        e_dn[t + 1] = 1;
        l = t + 2;
        e_rdy[l] = 1;
    endtask

    always @(negedge Clock) if (cmp_on && nReset) begin
        chk("ready", bus.Ready, e_rdy[cyc]);
        chk("nclear", bus.nClear, e_ncl[cyc]);
        chk("en_term", bus.Enable_Term, e_trm[cyc]);
        chk("en_odd", bus.Enable_Odd, e_odd[cyc]);
        chk("en_even", bus.Enable_Even, e_evn[cyc]);
        chk("en_errcnt", bus.Enable_Error_Counter, e_ec[cyc]);
        chk("done", bus.Done, e_dn[cyc]);
        chk("replay_count", bus.Replay_Count, e_rc[cyc]);
        chk("replay_fail", bus.Replay_Fail, e_rf[cyc]);
    end

    task automatic idle_checks(input string tag);
        chk({tag, "_ready"}, bus.Ready, 1);
        chk({tag, "_nclear"}, bus.nClear, 1);
        chk({tag, "_enables"}, {bus.Enable_Term, bus.Enable_Odd, bus.Enable_Even, bus.Enable_Error_Counter}, 0);
        chk({tag, "_done"}, bus.Done, 0);
        chk({tag, "_rcount"}, bus.Replay_Count, 0);
        chk({tag, "_rfail"}, bus.Replay_Fail, 0);
    endtask

    task automatic clear_err();
        for (int k = 0; k < MAXC; k++) errv[k] = 0;
    endtask

    task automatic run_frame(input int nh_in, input int rst_at);
        build_model(nh_in, len);
        cmp_on = 0;
        bus.Start = 1;
        bus.Num_Half_Iter = CNT_W'(nh_in);
        bus.Razor_Error = '0;
        @(posedge Clock); #1;
        cmp_on = 1;
        for (int k = 1; k <= len; k++) begin
            cyc = k;
            bus.Start = (k < len) ? 1'($urandom % 2) : 1'b0;
            bus.Num_Half_Iter = CNT_W'($urandom);
            bus.Razor_Error = errv[k] ? rv() : '0;
            if (k == rst_at) begin
                cmp_on = 0;
                #2 nReset = 0;
                #1 idle_checks("async_rst");
                bus.Start = 1;
                @(posedge Clock); #1;
                chk("rst_prio_ready", bus.Ready, 1);
                chk("rst_prio_nclear", bus.nClear, 1);
                bus.Start = 0;
                nReset = 1;
                @(posedge Clock); #1;
                chk("post_rst_ready", bus.Ready, 1);
                return;
            end
            @(posedge Clock); #1;
        end
        cmp_on = 0;
        bus.Start = 0;
        bus.Razor_Error = '0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; cmp_on = 0;
        nReset = 0;
        bus.Start = 0; bus.Num_Half_Iter = '0; bus.Razor_Error = '0;
        clear_err();
        repeat (2) @(posedge Clock);
        #1 idle_checks("reset");
        nReset = 1;
        @(posedge Clock); #1;
        // T1
        clear_err();
        run_frame(4, 0);
        chk("t1_len", len, 15);
        chk("t1_odd5", e_odd[5], 1);
        chk("t1_odd9", e_odd[9], 1);
        chk("t1_even7", e_evn[7], 1);
        chk("t1_even11", e_evn[11], 1);
        chk("t1_errcnt13", e_ec[13], 1);
        chk("t1_done14", e_dn[14], 1);
        chk("t1_rcount", bus.Replay_Count, 0);
        // T2
        clear_err();
        errv[8] = 1;
        run_frame(4, 0);
        chk("t2_even9", e_evn[9], 1);
        chk("t2_done16", e_dn[16], 1);
        chk("t2_rcount", bus.Replay_Count, 1);
        chk("t2_rfail", bus.Replay_Fail, 0);
        // T3
        clear_err();
        for (int k = 6; k < MAXC; k++) errv[k] = 1;
        run_frame(2, 0);
        chk("t3_len", len, 23);
        chk("t3_rcount", bus.Replay_Count, 6);
        chk("t3_rfail", bus.Replay_Fail, 1);
        // T4
        clear_err();
        run_frame(0, 0);
        chk("t4_len", len, 9);
        chk("t4_odd5", e_odd[5], 1);
        // T6
        clear_err();
        foreach (errv[k]) if ((k >= 2 && k <= 5) || k == 7 || k == 9 || k == 11) errv[k] = 1;
        run_frame(4, 0);
        chk("t6_len", len, 15);
        chk("t6_rcount", bus.Replay_Count, 0);
        // T5
        clear_err();
        run_frame(4, 7);
        run_frame(4, 0);
        chk("t5_len", len, 15);
        // randomized frames
        repeat (30) begin
            clear_err();
            for (int k = 0; k < MAXC; k++) errv[k] = ($urandom % 4 == 0);
            run_frame($urandom_range(0, 12), 0);
        end
        clear_err();
        for (int k = 0; k < MAXC; k++) errv[k] = ($urandom % 3 == 0);
        run_frame(63, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
